mips_fetch_stage: RTL
=====================

# mips_fetch_stage

Instruction-fetch stage of the MIPS pipeline. Holds the program counter, drives the address of the combinational instruction memory, and captures the returned word into the IF/ID pipeline register for decode. Handles in-order sequential fetch, control-flow redirects from later stages, hazard stalls and pipeline flushes. Also keeps a retired-fetch counter for debug.

## Interface
Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hazard unit: hold PC and IF/ID contents.
- flush  in  1  squash the instruction being captured into IF/ID and insert a bubble.
- redirect  in  1  branch, jump or jr taken; load redirect_pc.
- redirect_pc  in  32  target address; bits [1:0] ignored.
- imem_addr  out  32  byte address to instruction memory; equals current PC.
- imem_data  in  32  instruction word, valid combinationally in the same cycle.
- id_valid  out  1  IF/ID holds a real instruction.
- id_inst  out  32  IF/ID instruction; 32'h00000000 (sll $0,$0,0 NOP) when invalid.
- id_pc  out  32  address of id_inst.
- id_pc_plus4  out  32  id_pc + 4, for link and branch-offset computation.
- fetch_count  out  32  number of instructions accepted into IF/ID since reset.

## Operation
- The PC register is always word-aligned. imem_addr = pc, combinational.
- Next-PC priority per rising edge: rst > redirect > stall > sequential.
  - redirect: pc <= {redirect_pc[31:2], 2'b00}.
  - stall and no redirect: pc holds.
  - otherwise: pc <= pc + 4, modulo 2^32. 32'hFFFFFFFC wraps to 0.
- IF/ID update priority: rst > (redirect | flush) > stall > capture.
  - bubble: id_valid<=0, id_inst<=0. id_pc and id_pc_plus4 hold.
  - stall: all IF/ID fields hold.
  - capture: id_valid<=1, id_inst<=imem_data, id_pc<=pc, id_pc_plus4<=pc+4.
- flush without redirect: IF/ID takes a bubble. PC still follows the stall/sequential rule.
- redirect overrides stall. The stalled slot in IF/ID is discarded, because the redirecting stage is older.
- fetch_count increments by 1 on every capture edge only. It wraps at 2^32.

## Timing
- Reset (async assert, any time) immediately sets:
  - pc=RESET_PC, so imem_addr=RESET_PC.
  - id_valid=0, id_inst=0, id_pc=0, id_pc_plus4=0, fetch_count=0.
- Reset mid-operation discards IF/ID contents. No partial state survives.
- First rising edge after rst deasserts (no stall): IF/ID = {1, mem[RESET_PC], RESET_PC, RESET_PC+4}, pc=RESET_PC+4.
- Fetch latency is one cycle: the word addressed in cycle N is visible on id_* after edge N.
- Redirect sampled at edge N:
  - IF/ID becomes a bubble after edge N.
  - The target instruction appears in IF/ID after edge N+1.
  - Penalty is one bubble.
- Stall held for K cycles: imem_addr and id_* stay constant for K edges, then resume with no lost or duplicated instruction.
- All outputs are registered except imem_addr, which is driven directly from the pc flop.

## Structure
- Shared definitions header (mips_defs):
  - NOP encoding 32'h00000000.
  - PC increment constant 4.
  - Default RESET_PC.
  - Instruction/address width 32.
- One sub-module, mips_pc_reg: PC flop with async reset, next-PC mux, alignment masking and +4 adder. It exports pc and pc_plus4.
- The IF/ID register and fetch_count live in mips_fetch_stage.
- The instruction memory is external, connected through imem_addr/imem_data.

## Test plan
- Reset then free-run, with memory word 0 = 32'h24010001 and word 1 = 32'h00011100:
  - after edge 1: id_inst=24010001, id_pc=0, imem_addr=4.
  - after edge 2: id_inst=00011100, id_pc_plus4=8, fetch_count=2.
- Stall held 2 cycles while imem_addr=8: imem_addr stays 8 and id_* unchanged. On release, id_pc=8 with no skipped or duplicated word.
- Redirect and alignment, with redirect=1 and redirect_pc=32'h00000067 at one edge:
  - id_valid=0, id_inst=0, imem_addr=0x64.
  - next edge: id_pc=0x64.
- redirect and stall asserted together: redirect wins, pc=target and IF/ID gets a bubble. flush alone gives a bubble while pc advances by 4.
- RESET_PC=32'hFFFFFFFC: after the first edge, id_pc=FFFFFFFC, id_pc_plus4=0, imem_addr=0.
- Async reset pulsed between clock edges mid-run: outputs return to reset values immediately, without waiting for a clock edge. Fetch restarts at RESET_PC and fetch_count restarts at 0.

Source files
------------

// File: rtl/mips_fetch_stage_pkg.sv
// Shared MIPS fetch definitions: widths, NOP encoding, PC increment, reset PC
// and the IF/ID register layout.
package mips_fetch_stage_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INST         = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_INCR          = 32'd4;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] ALIGN_MASK       = 32'hFFFF_FFFC;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
  } ifid_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ALIGN_MASK;
  endfunction

endpackage

// File: rtl/mips_fetch_stage_if.sv
// Bundle between the fetch stage and its surroundings: hazard/redirect
// controls, instruction-memory port and the IF/ID outputs.
interface mips_fetch_stage_if;
  import mips_fetch_stage_pkg::*;

  logic            stall;
  logic            flush;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_data;
  logic            id_valid;
  logic [XLEN-1:0] id_inst;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_pc_plus4;
  logic [XLEN-1:0] fetch_count;

  // There is no valid/ready handshake here: imem_data is a combinational
  // response to imem_addr in the same cycle, and IF/ID advances every edge
  // unless stall holds it; redirect and flush replace the captured slot with a bubble.
  modport master (
    input  stall, flush, redirect, redirect_pc, imem_data,
    output imem_addr, id_valid, id_inst, id_pc, id_pc_plus4, fetch_count
  );

  modport slave (
    output stall, flush, redirect, redirect_pc, imem_data,
    input  imem_addr, id_valid, id_inst, id_pc, id_pc_plus4, fetch_count
  );

endinterface

// File: rtl/mips_fetch_stage_pc_reg.sv
// Program counter: async-reset flop, redirect/stall/sequential next-PC mux,
// word alignment and the +4 adder.
module mips_pc_reg
  import mips_fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            stall_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pc_plus4;

  assign pc_plus4 = pc_q + PC_INCR;

  // Redirect comes from an older instruction, so it beats a hazard stall.
  always_comb begin
    pc_d = pc_plus4;
    if (redirect_i) begin
      pc_d = word_align(redirect_pc_i);
    end else if (stall_i) begin
      pc_d = pc_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= word_align(RESET_PC);
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_plus4;

endmodule

// File: rtl/mips_fetch_stage.sv
// MIPS instruction-fetch stage: drives the instruction memory from the PC and
// captures the returned word into the IF/ID register; counts accepted fetches.
module mips_fetch_stage
  import mips_fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                clk,
  input  logic                rst,
  mips_fetch_stage_if.master  bus
);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  ifid_t           ifid_q;
  ifid_t           ifid_d;
  logic [XLEN-1:0] count_q;
  logic [XLEN-1:0] count_d;

  mips_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk           (clk),
    .rst           (rst),
    .redirect_i    (bus.redirect),
    .redirect_pc_i (bus.redirect_pc),
    .stall_i       (bus.stall),
    .pc_o          (pc),
    .pc_plus4_o    (pc_plus4)
  );

  assign bus.imem_addr = pc;

  // A bubble keeps the old id_pc/id_pc_plus4; only valid and inst are cleared.
  always_comb begin
    ifid_d  = ifid_q;
    count_d = count_q;
    if (bus.redirect || bus.flush) begin
      ifid_d.valid = 1'b0;
      ifid_d.inst  = NOP_INST;
    end else if (!bus.stall) begin
      ifid_d.valid    = 1'b1;
      ifid_d.inst     = bus.imem_data;
      ifid_d.pc       = pc;
      ifid_d.pc_plus4 = pc_plus4;
      count_d         = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifid_q  <= '0;
      count_q <= '0;
    end else begin
      ifid_q  <= ifid_d;
      count_q <= count_d;
    end
  end

  assign bus.id_valid    = ifid_q.valid;
  assign bus.id_inst     = ifid_q.inst;
  assign bus.id_pc       = ifid_q.pc;
  assign bus.id_pc_plus4 = ifid_q.pc_plus4;
  assign bus.fetch_count = count_q;

endmodule
